// File: rtl/development_stage_tracker.sv
// development_stage_tracker
// Saturating N-bit maturity level driven by regulator commands, mapped onto
// 2^STAGE_BITS development stages with hysteresis, minimum dwell time after
// each stage change and optional non-regression of the stage.
module development_stage_tracker #(
    parameter int N             = 9,
    parameter int STAGE_BITS    = 2,
    parameter int FAST_STEP     = 2,
    parameter int SET_VAL       = 0,
    parameter int DEFAULT_VAL   = 0,
    parameter int HYST          = 4,
    parameter int MIN_DWELL     = 8,
    parameter int ALLOW_REGRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  fast,
    input  logic                  setval,
    output logic [N-1:0]          level,
    output logic [STAGE_BITS-1:0] stage,
    output logic                  stage_up,
    output logic                  stage_down,
    output logic                  dwell_busy
);

    localparam int BIN    = 1 << (N - STAGE_BITS);
    localparam int NSTAGE = 1 << STAGE_BITS;
    // Threshold width: (SMAX+1)*BIN+HYST can exceed 2^N, so keep two spare bits.
    localparam int TW     = N + 2;
    localparam int DW     = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

    localparam logic [N-1:0]          SET_LVL    = N'(SET_VAL);
    localparam logic [N-1:0]          DEF_LVL    = N'(DEFAULT_VAL);
    localparam logic [STAGE_BITS-1:0] SET_STG    = SET_LVL[N-1 -: STAGE_BITS];
    localparam logic [STAGE_BITS-1:0] DEF_STG    = DEF_LVL[N-1 -: STAGE_BITS];
    localparam logic [STAGE_BITS-1:0] STG_MAX    = '1;
    localparam logic [N:0]            LVL_MAX    = {1'b0, {N{1'b1}}};
    localparam logic [N:0]            FAST_EXT   = (N + 1)'(FAST_STEP);
    localparam logic [N:0]            ONE_EXT    = (N + 1)'(1);
    localparam logic [DW-1:0]         DWELL_LOAD = DW'(MIN_DWELL);
    localparam logic [DW-1:0]         DWELL_ONE  = DW'(1);

    logic [N-1:0]          level_reg, level_next;
    logic [STAGE_BITS-1:0] stage_reg, stage_next;
    logic [DW-1:0]         dwell_reg, dwell_next;
    logic                  up_reg, up_next;
    logic                  down_reg, down_next;

    logic [N:0]            step;
    logic [N:0]            sum;
    logic [TW-1:0]         lvl_ext;

    // Per-stage promote / demote thresholds, constant for a given build.
    logic [TW-1:0] promote_thr [NSTAGE];
    logic [TW-1:0] demote_thr  [NSTAGE];

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_thr
            assign promote_thr[gi] = TW'((gi + 1) * BIN + HYST);
            if (gi == 0) begin : g_first
                // Stage 0 can never demote; threshold is a don't-care.
                assign demote_thr[gi] = '0;
            end else begin : g_rest
                assign demote_thr[gi] = TW'(gi * BIN - HYST);
            end
        end
    endgenerate

    // Level update: setval load, else saturating step up/down, else hold.
    always_comb begin
        step       = fast ? FAST_EXT : ONE_EXT;
        sum        = {1'b0, level_reg} + step;
        level_next = level_reg;
        if (setval) begin
            level_next = SET_LVL;
        end else if (inc && !dec) begin
            level_next = (sum > LVL_MAX) ? LVL_MAX[N-1:0] : sum[N-1:0];
        end else if (dec && !inc) begin
            level_next = ({1'b0, level_reg} < step) ? '0 : (level_reg - step[N-1:0]);
        end
    end

    // Stage evaluation on the registered level: setval override, dwell
    // countdown, then at most one promote or demote step per cycle.
    always_comb begin
        stage_next = stage_reg;
        dwell_next = dwell_reg;
        up_next    = 1'b0;
        down_next  = 1'b0;
        lvl_ext    = {2'b00, level_reg};
        if (setval) begin
            stage_next = SET_STG;
            dwell_next = '0;
            up_next    = (SET_STG > stage_reg);
            down_next  = (SET_STG < stage_reg);
        end else if (dwell_reg != '0) begin
            dwell_next = dwell_reg - DWELL_ONE;
        end else if ((stage_reg != STG_MAX) && (lvl_ext >= promote_thr[stage_reg])) begin
            stage_next = stage_reg + 1'b1;
            dwell_next = DWELL_LOAD;
            up_next    = 1'b1;
        end else if ((ALLOW_REGRESS != 0) && (stage_reg != '0) &&
                     (lvl_ext < demote_thr[stage_reg])) begin
            stage_next = stage_reg - 1'b1;
            dwell_next = DWELL_LOAD;
            down_next  = 1'b1;
        end
    end

    // State registers with synchronous reset; pulses reset to zero so a
    // reset in the middle of a walk never emits an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg <= DEF_LVL;
            stage_reg <= DEF_STG;
            dwell_reg <= '0;
            up_reg    <= 1'b0;
            down_reg  <= 1'b0;
        end else begin
            level_reg <= level_next;
            stage_reg <= stage_next;
            dwell_reg <= dwell_next;
            up_reg    <= up_next;
            down_reg  <= down_next;
        end
    end

    assign level      = level_reg;
    assign stage      = stage_reg;
    assign stage_up   = up_reg;
    assign stage_down = down_reg;
    assign dwell_busy = (dwell_reg != '0);

endmodule

// File: tb/tb_development_stage_tracker.sv
// Directed testbench for development_stage_tracker: a vector table for
// basic level arithmetic plus hand sequences for thresholds, dwell, walking,
// non-regression, setval and reset-in-dwell.
module tb_development_stage_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_b = 1'b1;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       fast = 1'b0;
    logic       setval = 1'b0;

    logic [8:0] level, level_b;
    logic [1:0] stage, stage_b;
    logic       up, down, busy;
    logic       up_b, down_b, busy_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    development_stage_tracker dut (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
        .level(level), .stage(stage), .stage_up(up), .stage_down(down),
        .dwell_busy(busy)
    );

    development_stage_tracker #(.ALLOW_REGRESS(0)) dut_nr (
        .clk(clk), .rst(rst_b), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
        .level(level_b), .stage(stage_b), .stage_up(up_b), .stage_down(down_b),
        .dwell_busy(busy_b)
    );

    typedef struct {
        logic       inc;
        logic       dec;
        logic       fast;
        logic       setval;
        logic [8:0] lvl;
        logic [1:0] stg;
        logic       up;
        logic       down;
        logic       busy;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cmd(input logic i, input logic d, input logic f, input logic s);
        inc = i; dec = d; fast = f; setval = s;
    endtask

    task automatic chk_a(input string tag, input int lv, input int st,
                         input int u, input int dn, input int bz);
        chk({tag, ".level"}, 32'(level), 32'(lv));
        chk({tag, ".stage"}, 32'(stage), 32'(st));
        chk({tag, ".up"},    32'(up),    32'(u));
        chk({tag, ".down"},  32'(down),  32'(dn));
        chk({tag, ".busy"},  32'(busy),  32'(bz));
    endtask

    function automatic int walk_stage(input int j);
        if (j < 9)   return 0;
        if (j < 71)  return 1;
        if (j < 135) return 2;
        return 3;
    endfunction

    function automatic int walk_busy(input int j);
        if (j <= 7) return 1;
        if (j >= 9 && j <= 16) return 1;
        if (j >= 71 && j <= 78) return 1;
        if (j >= 135 && j <= 142) return 1;
        return 0;
    endfunction

    initial begin
        int exp_lvl;
        int found;

        //               inc   dec   fast  setv  lvl  stg up down busy
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 9'd1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd3, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'd2, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd2, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 9'd2, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 9'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'd1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'd1, 2'd0, 1'b0, 1'b0, 1'b0};

        // Reset
        tick();
        tick();
        chk_a("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Table: level arithmetic, saturation at 0, inc&dec hold, setval priority
        for (int i = 0; i < 12; i++) begin
            set_cmd(vecs[i].inc, vecs[i].dec, vecs[i].fast, vecs[i].setval);
            tick();
            $display("vec %0d: inc=%0b dec=%0b fast=%0b setval=%0b -> level=%0d stage=%0d up=%0b down=%0b busy=%0b",
                     i, vecs[i].inc, vecs[i].dec, vecs[i].fast, vecs[i].setval,
                     level, stage, up, down, busy);
            chk_a($sformatf("vec%0d", i), int'(vecs[i].lvl), int'(vecs[i].stg),
                  int'(vecs[i].up), int'(vecs[i].down), int'(vecs[i].busy));
        end

        // Climb to 131: no promotion below 128+HYST
        set_cmd(1, 0, 0, 0);
        repeat (130) tick();
        chk_a("at131", 131, 0, 0, 0, 0);
        tick();
        chk_a("at132", 132, 0, 0, 0, 0);
        set_cmd(0, 0, 0, 0);
        tick();
        chk_a("promote1", 132, 1, 1, 0, 1);
        tick();
        chk_a("promote1_next", 132, 1, 0, 0, 1);

        // Fast dec below 124 while dwell is busy: demotion must wait for dwell
        set_cmd(0, 1, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_a($sformatf("dwelldec%0d", k), 132 - 2 * k, 1, 0, 0, 1);
        end
        set_cmd(0, 0, 0, 0);
        tick();
        chk_a("dwell_clear", 120, 1, 0, 0, 0);
        tick();
        chk_a("demote0", 120, 0, 0, 1, 1);

        // Fast climb to saturation: stage walks one step per permitted cycle
        set_cmd(1, 0, 1, 0);
        for (int j = 1; j <= 220; j++) begin
            tick();
            exp_lvl = 120 + 2 * j;
            if (exp_lvl > 511) exp_lvl = 511;
            chk_a($sformatf("walk%0d", j), exp_lvl, walk_stage(j),
                  (j == 9 || j == 71 || j == 135) ? 1 : 0, 0, walk_busy(j));
        end

        // Non-regressing instance: climb to stage 3, fall to 0, stage holds
        set_cmd(0, 0, 0, 0);
        tick();
        chk("nr.reset.level", 32'(level_b), 32'd0);
        chk("nr.reset.stage", 32'(stage_b), 32'd0);
        rst_b = 1'b0;
        set_cmd(1, 0, 1, 0);
        repeat (260) tick();
        chk("nr.top.level", 32'(level_b), 32'd511);
        chk("nr.top.stage", 32'(stage_b), 32'd3);
        set_cmd(0, 1, 1, 0);
        for (int k = 1; k <= 260; k++) begin
            tick();
            chk($sformatf("nr.fall%0d.stage", k), 32'(stage_b), 32'd3);
            chk($sformatf("nr.fall%0d.down", k), 32'(down_b), 32'd0);
        end
        chk("nr.bottom.level", 32'(level_b), 32'd0);
        set_cmd(0, 0, 0, 1);
        tick();
        chk("nr.setval.level", 32'(level_b), 32'd0);
        chk("nr.setval.stage", 32'(stage_b), 32'd0);
        chk("nr.setval.down", 32'(down_b), 32'd1);
        chk("nr.setval.up", 32'(up_b), 32'd0);
        set_cmd(0, 0, 0, 0);
        tick();
        chk("nr.after.down", 32'(down_b), 32'd0);
        chk("nr.after.busy", 32'(busy_b), 32'd0);

        // inc&dec hold at level 50, then setval beats inc
        set_cmd(1, 0, 1, 0);
        repeat (25) tick();
        chk_a("lvl50", 50, 0, 0, 0, 0);
        set_cmd(1, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_a($sformatf("incdec%0d", k), 50, 0, 0, 0, 0);
        end
        set_cmd(1, 0, 0, 1);
        tick();
        chk_a("setval_inc", 0, 0, 0, 0, 0);

        // Climb until stage 2 is reached, then reset mid-dwell
        set_cmd(1, 0, 1, 0);
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            tick();
            if (stage == 2'd2) found = 1;
        end
        chk("reach_stage2", 32'(found), 32'd1);
        chk("stage2.busy", 32'(busy), 32'd1);
        chk("stage2.up", 32'(up), 32'd1);
        set_cmd(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk_a("rst_mid_dwell", 0, 0, 0, 0, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
